issue_queue_age: RTL and testbench

//  Parametrised out-of-order issue queue placed between rename and execute.

---
 rtl/issue_queue_age.sv | 203 ++++++++++++++++++++
 tb/tb_issue_queue_age.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_age.sv
// issue_queue_age: out-of-order issue queue with multi-port operand wakeup,
// enqueue bypass from the broadcast ports, oldest-ready select through an
// age matrix, and an occupancy counter.
module issue_queue_age #(
  parameter int DEPTH     = 16,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 138,
  parameter int SEQ_W     = 8,
  parameter int NUM_WB    = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FLUSH,
  input  logic                        STALL,
  input  logic                        enq_valid,
  output logic                        enq_ready,
  input  logic [PAYLOAD_W-1:0]        enq_payload,
  input  logic [SEQ_W-1:0]            enq_seq,
  input  logic [3*TAG_W-1:0]          enq_tag,
  input  logic [2:0]                  enq_rdy,
  input  logic [3*DATA_W-1:0]         enq_val,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]     wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]    wb_val,
  output logic                        iss_valid,
  output logic [PAYLOAD_W-1:0]        iss_payload,
  output logic [SEQ_W-1:0]            iss_seq,
  output logic [3*DATA_W-1:0]         iss_opnd,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  // Per-entry state. younger_q[i][j] = 1 means entry i was enqueued after entry j.
  logic [DEPTH-1:0]     valid_q;
  logic [2:0]           src_rdy_q  [DEPTH];
  logic [DEPTH-1:0]     younger_q  [DEPTH];
  logic [TAG_W-1:0]     src_tag_q  [DEPTH][3];
  logic [DATA_W-1:0]    src_val_q  [DEPTH][3];
  logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
  logic [SEQ_W-1:0]     seq_q      [DEPTH];

  // Combinational decisions for the current cycle.
  logic [2:0]           wake_hit   [DEPTH];
  logic [DATA_W-1:0]    wake_val   [DEPTH][3];
  logic [2:0]           enq_src_rdy;
  logic [DATA_W-1:0]    enq_src_val [3];
  logic [DEPTH-1:0]     elig;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic [DEPTH-1:0]     gnt_oh;
  logic [IDX_W-1:0]     free_idx;
  logic [DEPTH-1:0]     free_oh;
  logic                 enq_fire;
  logic                 iss_fire;
  logic [DEPTH-1:0]     iss_clr;
  logic [DEPTH-1:0]     col_clr;

  // Broadcast lookup: {hit, value}; scanning from the top port down lets the
  // lowest-index matching port overwrite any higher one.
  function automatic logic [DATA_W:0] wb_match(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_WB-1:0]        v,
    input logic [NUM_WB*TAG_W-1:0]  tags,
    input logic [NUM_WB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (v[p] && (tags[p*TAG_W +: TAG_W] == tag)) r = {1'b1, vals[p*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign enq_ready = (count != CNT_W'(DEPTH)) && !STALL;
  assign enq_fire  = enq_valid && enq_ready;
  assign iss_fire  = gnt_valid && !STALL;
  assign iss_clr   = iss_fire ? gnt_oh : '0;
  assign col_clr   = iss_clr | (enq_fire ? free_oh : '0);

  // Wakeup: which waiting sources of valid entries see their tag broadcast now.
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
    for (int i = 0; i < DEPTH; i++) begin
      wake_hit[i] = '0;
      for (int s = 0; s < 3; s++) begin
        logic [DATA_W:0] m;
        wake_val[i][s] = '0;
        m = wb_match(src_tag_q[i][s], wb_valid, wb_tag, wb_val);
        if (valid_q[i] && !src_rdy_q[i][s] && m[DATA_W]) begin
          wake_hit[i][s] = 1'b1;
          wake_val[i][s] = m[DATA_W-1:0];
        end
      end
    end
  end

  // Enqueue readiness: rename-ready or tag 0 take enq_val, else bypass from a broadcast.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      logic [DATA_W:0] m;
      m = wb_match(enq_tag[s*TAG_W +: TAG_W], wb_valid, wb_tag, wb_val);
      enq_src_rdy[s] = 1'b0;
      enq_src_val[s] = enq_val[s*DATA_W +: DATA_W];
      if (enq_rdy[s] || (enq_tag[s*TAG_W +: TAG_W] == '0)) begin
        enq_src_rdy[s] = 1'b1;
      end else if (m[DATA_W]) begin
        enq_src_rdy[s] = 1'b1;
        enq_src_val[s] = m[DATA_W-1:0];
      end
    end
  end

  // Select: the eligible entry that is younger than no other eligible entry.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] && (&src_rdy_q[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!gnt_valid && elig[i] && ((younger_q[i] & elig) == '0)) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(i);
        gnt_oh[i] = 1'b1;
      end
    end
  end

  // Free list: lowest-index invalid entry, taken from registered valid bits only.
  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    free_oh  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && !valid_q[i]) begin
        found      = 1'b1;
        free_idx   = IDX_W'(i);
        free_oh[i] = 1'b1;
      end
    end
  end

  // Control state: valid/ready bits, age matrix, occupancy and the issue register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET || FLUSH) begin
      valid_q     <= '0;
      count       <= '0;
      iss_valid   <= 1'b0;
      iss_payload <= '0;
      iss_seq     <= '0;
      iss_opnd    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src_rdy_q[i] <= '0;
        younger_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        src_rdy_q[i] <= src_rdy_q[i] | wake_hit[i];
        younger_q[i] <= younger_q[i] & ~col_clr;
      end
      if (iss_fire) valid_q[gnt_idx] <= 1'b0;
      if (enq_fire) begin
        valid_q[free_idx]   <= 1'b1;
        src_rdy_q[free_idx] <= enq_src_rdy;
        younger_q[free_idx] <= valid_q & ~iss_clr;
      end
      if (!STALL) begin
        iss_valid <= gnt_valid;
        if (gnt_valid) begin
          iss_payload <= payload_q[gnt_idx];
          iss_seq     <= seq_q[gnt_idx];
          iss_opnd    <= {src_val_q[gnt_idx][2], src_val_q[gnt_idx][1], src_val_q[gnt_idx][0]};
        end
      end
      count <= count + CNT_W'(enq_fire) - CNT_W'(iss_fire);
    end
  end

  // Entry storage: payloads, tags and operand values; validity lives in valid_q.
  always_ff @(posedge CLK) begin
    // NOTE: storage arrays are not reset; they are only read behind a set valid/ready bit.
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (wake_hit[i][s]) src_val_q[i][s] <= wake_val[i][s];
      end
    end
    if (enq_fire) begin
      payload_q[free_idx] <= enq_payload;
      seq_q[free_idx]     <= enq_seq;
      for (int s = 0; s < 3; s++) begin
        src_tag_q[free_idx][s] <= enq_tag[s*TAG_W +: TAG_W];
        src_val_q[free_idx][s] <= enq_src_val[s];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_age.sv
// tb_issue_queue_age: directed scenarios plus randomized traffic, checked
// against an age-ordered queue model of the issue queue.
module tb_issue_queue_age;

  localparam int DEPTH = 16;

  typedef logic [191:0] wide_t;

  typedef struct {
    logic [137:0]     payload;
    logic [7:0]       seq;
    logic [2:0][5:0]  tag;
    logic [2:0]       rdy;
    logic [2:0][31:0] val;
  } ent_t;

  logic          CLK = 1'b0;
  logic          RESET, FLUSH, STALL;
  logic          enq_valid;
  logic          enq_ready;
  logic [137:0]  enq_payload;
  logic [7:0]    enq_seq;
  logic [17:0]   enq_tag;
  logic [2:0]    enq_rdy;
  logic [95:0]   enq_val;
  logic [1:0]    wb_valid;
  logic [11:0]   wb_tag;
  logic [63:0]   wb_val;
  logic          iss_valid;
  logic [137:0]  iss_payload;
  logic [7:0]    iss_seq;
  logic [95:0]   iss_opnd;
  logic [4:0]    count;

  issue_queue_age dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
    .enq_seq(enq_seq), .enq_tag(enq_tag), .enq_rdy(enq_rdy), .enq_val(enq_val),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .iss_valid(iss_valid), .iss_payload(iss_payload), .iss_seq(iss_seq),
    .iss_opnd(iss_opnd), .count(count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: entries kept in enqueue (age) order, plus the issue register.
  ent_t          mq[$];
  logic          m_iss_valid;
  logic [137:0]  m_iss_payload;
  logic [7:0]    m_iss_seq;
  logic [95:0]   m_iss_opnd;
  logic [7:0]    seq_ctr = 8'd0;

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lowest-numbered valid broadcast port carrying the tag supplies the value.
  function automatic bit wb_lookup(input logic [5:0] t, output logic [31:0] v);
    v = '0;
    for (int p = 0; p < 2; p++) begin
      if (wb_valid[p] && wb_tag[p*6 +: 6] == t) begin
        v = wb_val[p*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    enq_valid = 1'b0;
    enq_rdy   = '0;
    wb_valid  = '0;
    STALL     = 1'b0;
    FLUSH     = 1'b0;
  endtask

  task automatic set_enq(input logic [5:0] t_c, t_b, t_a, input logic [2:0] rdy,
                         input logic [31:0] v_c, v_b, v_a);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    enq_valid   = 1'b1;
    enq_tag     = {t_c, t_b, t_a};
    enq_rdy     = rdy;
    enq_val     = {v_c, v_b, v_a};
    enq_payload = r[137:0];
    enq_seq     = seq_ctr;
    seq_ctr     = seq_ctr + 8'd1;
  endtask

  task automatic set_wb(input int port, input logic [5:0] t, input logic [31:0] v);
    wb_valid[port]         = 1'b1;
    wb_tag[port*6 +: 6]    = t;
    wb_val[port*32 +: 32]  = v;
  endtask

  // One clock: check enq_ready, advance the model across the edge, compare outputs.
  task automatic step();
    int   g;
    bit   fire_enq;
    ent_t ne;
    logic [31:0] v;
    #1;
    check("enq_ready", wide_t'(enq_ready), wide_t'((mq.size() != DEPTH) && !STALL));
    fire_enq = enq_valid && (mq.size() < DEPTH) && !STALL;
    g = -1;
    foreach (mq[k]) if (g < 0 && (&mq[k].rdy)) g = k;
    ne.payload = enq_payload;
    ne.seq     = enq_seq;
    for (int s = 0; s < 3; s++) begin
      ne.tag[s] = enq_tag[s*6 +: 6];
      ne.val[s] = enq_val[s*32 +: 32];
      ne.rdy[s] = 1'b0;
      if (enq_rdy[s] || ne.tag[s] == 6'd0) ne.rdy[s] = 1'b1;
      else if (wb_lookup(ne.tag[s], v)) begin
        ne.rdy[s] = 1'b1;
        ne.val[s] = v;
      end
    end
    @(posedge CLK);
    if (RESET || FLUSH) begin
      mq.delete();
      m_iss_valid = 1'b0; m_iss_payload = '0; m_iss_seq = '0; m_iss_opnd = '0;
    end else begin
      if (!STALL) begin
        if (g >= 0) begin
          m_iss_valid   = 1'b1;
          m_iss_payload = mq[g].payload;
          m_iss_seq     = mq[g].seq;
          m_iss_opnd    = mq[g].val;
          mq.delete(g);
        end else begin
          m_iss_valid = 1'b0;
        end
      end
      for (int k = 0; k < mq.size(); k++) begin
        ent_t e;
        e = mq[k];
        for (int s = 0; s < 3; s++) begin
          if (!e.rdy[s] && wb_lookup(e.tag[s], v)) begin
            e.rdy[s] = 1'b1;
            e.val[s] = v;
          end
        end
        mq[k] = e;
      end
      if (fire_enq) mq.push_back(ne);
    end
    #1;
    check("count",       wide_t'(count),       wide_t'(mq.size()));
    check("iss_valid",   wide_t'(iss_valid),   wide_t'(m_iss_valid));
    check("iss_payload", wide_t'(iss_payload), wide_t'(m_iss_payload));
    check("iss_seq",     wide_t'(iss_seq),     wide_t'(m_iss_seq));
    check("iss_opnd",    wide_t'(iss_opnd),    wide_t'(m_iss_opnd));
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s0, sp, sq, sr;
    m_iss_valid = 1'b0; m_iss_payload = '0; m_iss_seq = '0; m_iss_opnd = '0;
    enq_payload = '0; enq_seq = '0; enq_tag = '0; enq_val = '0;
    wb_tag = '0; wb_val = '0;
    idle_inputs();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    step();
    check("reset_count", wide_t'(count), wide_t'(0));
    check("reset_iss_valid", wide_t'(iss_valid), wide_t'(0));
    RESET = 1'b0;

    // 1: all-zero tags are ready at once; issue on the following edge.
    set_enq(6'd0, 6'd0, 6'd0, 3'b000, 32'd0, 32'd7, 32'd5);
    step();
    check("t1_count_after_enq", wide_t'(count), wide_t'(1));
    idle_inputs();
    step();
    check("t1_iss_valid", wide_t'(iss_valid), wide_t'(1));
    check("t1_opnd_a", wide_t'(iss_opnd[31:0]), wide_t'(32'd5));
    check("t1_opnd_b", wide_t'(iss_opnd[63:32]), wide_t'(32'd7));
    check("t1_count_zero", wide_t'(count), wide_t'(0));

    // 2: a waiting older entry is bypassed by a ready younger one, then woken.
    set_enq(6'd0, 6'd0, 6'd9, 3'b000, 32'd1, 32'd2, 32'd0);
    s0 = enq_seq;
    step();
    set_enq(6'd0, 6'd0, 6'd0, 3'b111, 32'd3, 32'd4, 32'd6);
    step();
    idle_inputs();
    step();
    set_wb(0, 6'd9, 32'h55);
    step();
    idle_inputs();
    step();
    check("t2_old_seq", wide_t'(iss_seq), wide_t'(s0));
    check("t2_woken_a", wide_t'(iss_opnd[31:0]), wide_t'(32'h55));

    // 3: refill holes so slot order (2,0,1) differs from age order.
    set_enq(6'd0, 6'd0, 6'd20, 3'b000, 32'd0, 32'd0, 32'd0); step();
    set_enq(6'd0, 6'd0, 6'd21, 3'b000, 32'd0, 32'd0, 32'd0); step();
    set_enq(6'd0, 6'd0, 6'd22, 3'b000, 32'd0, 32'd0, 32'd0); step();
    idle_inputs(); set_wb(0, 6'd22, 32'hc2); step();
    drain(1);
    set_enq(6'd0, 6'd0, 6'd30, 3'b000, 32'd0, 32'd0, 32'd0); sp = enq_seq; step();
    idle_inputs(); set_wb(1, 6'd20, 32'ha0); step();
    drain(1);
    set_enq(6'd0, 6'd0, 6'd30, 3'b000, 32'd0, 32'd0, 32'd0); sq = enq_seq; step();
    idle_inputs(); set_wb(0, 6'd21, 32'hb1); step();
    drain(1);
    set_enq(6'd0, 6'd0, 6'd30, 3'b000, 32'd0, 32'd0, 32'd0); sr = enq_seq; step();
    idle_inputs(); set_wb(1, 6'd30, 32'h30); step();
    drain(1); check("t3_first",  wide_t'(iss_seq), wide_t'(sp));
    drain(1); check("t3_second", wide_t'(iss_seq), wide_t'(sq));
    drain(1); check("t3_third",  wide_t'(iss_seq), wide_t'(sr));
    drain(2);

    // 4: fill to capacity; a same-cycle issue does not reopen the slot.
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(6'd0, 6'd0, 6'd40, 3'b000, 32'd0, 32'd0, 32'(i));
      step();
    end
    check("t4_full_count", wide_t'(count), wide_t'(DEPTH));
    set_enq(6'd0, 6'd0, 6'd0, 3'b111, 32'd0, 32'd0, 32'd0);
    step();
    check("t4_full_ready", wide_t'(enq_ready), wide_t'(0));
    set_wb(0, 6'd40, 32'h40);
    step();
    wb_valid = '0;
    step();
    check("t4_count_15", wide_t'(count), wide_t'(15));
    step();
    drain(20);

    // 5: enqueue bypass from broadcast port 1.
    set_enq(6'd0, 6'd0, 6'd12, 3'b000, 32'd0, 32'd0, 32'd0);
    set_wb(1, 6'd12, 32'hab);
    step();
    idle_inputs();
    step();
    check("t5_bypass_a", wide_t'(iss_opnd[31:0]), wide_t'(32'hab));

    // 6: flush with five waiting entries and a concurrent enqueue.
    for (int i = 0; i < 5; i++) begin
      set_enq(6'd0, 6'd0, 6'd50, 3'b000, 32'd0, 32'd0, 32'd0);
      step();
    end
    set_enq(6'd0, 6'd0, 6'd0, 3'b111, 32'd0, 32'd0, 32'd0);
    FLUSH = 1'b1;
    step();
    check("t6_flush_count", wide_t'(count), wide_t'(0));
    check("t6_flush_iss", wide_t'(iss_valid), wide_t'(0));
    idle_inputs(); set_wb(0, 6'd50, 32'h50); step();
    drain(3);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 60)
        set_enq(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                3'($urandom), $urandom, $urandom, $urandom);
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 99) < 40) set_wb(p, 6'($urandom_range(0, 15)), $urandom);
      STALL = ($urandom_range(0, 99) < 10);
      FLUSH = ($urandom_range(0, 99) < 2);
      step();
    end
    drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
